// File: rtl/fetch_pc_unit.sv
// IF-stage program counter: next-PC selection, fetch fault detection,
// fault pending and double-fault lock.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 4096,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_pc_stall,
  input  logic              i_branch_taken_e,
  input  logic [31:0]       i_branch_target_e,
  input  logic              i_trap_enter_m,
  input  logic [31:0]       i_trap_vector,
  input  logic              i_mret_m,
  input  logic [31:0]       i_mepc,
  output logic [31:0]       o_pc_f,
  output logic [31:0]       o_pc_p4_f,
  output logic [3:0]        o_exception_code_f,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_fetch_valid,
  output logic              o_locked
);

  localparam int unsigned PC_W        = 32;
  localparam int unsigned CODE_W      = 4;
  localparam logic [CODE_W-1:0] CODE_NONE  = 4'b1111;
  localparam logic [CODE_W-1:0] CODE_MISAL = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_ACC   = 4'b0001;
  localparam logic [PC_W-1:0]   IMEM_LIMIT = PC_W'(IMEM_BYTES);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PEND = 2'b01,
    ST_VEC  = 2'b10,
    ST_LOCK = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fault_c;
  logic [CODE_W-1:0] fault_code_c;

  // Fault decode on the current PC; misalignment wins over range.
  always_comb begin
    fault_c      = 1'b0;
    fault_code_c = CODE_NONE;
    if (pc_q[1:0] != 2'b00) begin
      fault_c      = 1'b1;
      fault_code_c = CODE_MISAL;
    end else if (pc_q >= IMEM_LIMIT) begin
      fault_c      = 1'b1;
      fault_code_c = CODE_ACC;
    end
  end

  // Next-PC and state selection in priority order.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (state_q != ST_LOCK) begin
      if (i_trap_enter_m) begin
        pc_d    = {i_trap_vector[31:2], 2'b00};
        state_d = ST_VEC;
      end else if (i_mret_m) begin
        pc_d    = i_mepc;
        state_d = ST_RUN;
      end else if (i_branch_taken_e) begin
        pc_d    = i_branch_target_e;
        state_d = ST_RUN;
      end else if (fault_c) begin
        state_d = (state_q == ST_VEC) ? ST_LOCK : ST_PEND;
      end else if (i_pc_stall || (state_q == ST_PEND)) begin
        pc_d    = pc_q;
      end else begin
        pc_d    = pc_q + PC_W'(4);
        state_d = ST_RUN;
      end
    end
  end

  // State and PC registers, gated by the global clock enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else if (i_clk_en) begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Fetch-side outputs decoded from the registered PC and state.
  always_comb begin
    o_pc_f             = pc_q;
    o_pc_p4_f          = pc_q + PC_W'(4);
    o_imem_addr        = pc_q[ADDR_W+1:2];
    o_exception_code_f = (state_q == ST_LOCK) ? CODE_NONE : fault_code_c;
    o_fetch_valid      = ((state_q == ST_RUN) || (state_q == ST_VEC)) && !fault_c;
    o_locked           = (state_q == ST_LOCK);
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        pc_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] pc_f;
  logic [31:0] pc_p4_f;
  logic [3:0]  code;
  logic [9:0]  imem_addr;
  logic        fvalid;
  logic        locked;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(4096),
    .ADDR_W    (10)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_clk_en          (clk_en),
    .i_pc_stall        (pc_stall),
    .i_branch_taken_e  (br_taken),
    .i_branch_target_e (br_target),
    .i_trap_enter_m    (trap),
    .i_trap_vector     (trap_vec),
    .i_mret_m          (mret),
    .i_mepc            (mepc),
    .o_pc_f            (pc_f),
    .o_pc_p4_f         (pc_p4_f),
    .o_exception_code_f(code),
    .o_imem_addr       (imem_addr),
    .o_fetch_valid     (fvalid),
    .o_locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run overruns its budget.
  initial begin
    #100000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_f, 32'h0); end
    checks++; if (code !== 4'hF) begin errors++; $display("FAIL reset_code: got %h exp %h", code, 4'hF); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b exp 0", locked); end
    step();
    rst_n = 1'b1;
    checks++; if (pc_p4_f !== 32'h4) begin errors++; $display("FAIL reset_p4: got %h exp %h", pc_p4_f, 32'h4); end
    checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b exp 1", fvalid); end
    step();
    checks++; if (pc_f !== 32'h4 || pc_p4_f !== 32'h8) begin errors++; $display("FAIL run_pc1: got %h/%h exp 4/8", pc_f, pc_p4_f); end
    step();
    checks++; if (pc_f !== 32'h8 || pc_p4_f !== 32'hC) begin errors++; $display("FAIL run_pc2: got %h/%h exp 8/C", pc_f, pc_p4_f); end
    step();
    checks++; if (pc_f !== 32'hC || pc_p4_f !== 32'h10) begin errors++; $display("FAIL run_pc3: got %h/%h exp C/10", pc_f, pc_p4_f); end
    checks++; if (imem_addr !== 10'h3 || code !== 4'hF) begin errors++; $display("FAIL run_addr: got %h/%h exp 3/F", imem_addr, code); end
  endtask

  task automatic test_stall_branch();
    pc_stall = 1'b1; br_taken = 1'b1; br_target = 32'h100;
    step();
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL branch_over_stall: got %h exp %h", pc_f, 32'h100); end
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, pc_f, 32'h100); end
    end
    pc_stall = 1'b0;
    step();
    checks++; if (pc_f !== 32'h104) begin errors++; $display("FAIL stall_release: got %h exp %h", pc_f, 32'h104); end
  endtask

  task automatic test_pend_trap();
    br_taken = 1'b1; br_target = 32'h102;
    step();
    br_taken = 1'b0;
    checks++; if (pc_f !== 32'h102 || code !== 4'h0 || fvalid !== 1'b0) begin errors++; $display("FAIL misal_fetch: got %h/%h/%b exp 102/0/0", pc_f, code, fvalid); end
    step();
    step();
    checks++; if (pc_f !== 32'h102 || code !== 4'h0 || fvalid !== 1'b0) begin errors++; $display("FAIL pend_hold: got %h/%h/%b exp 102/0/0", pc_f, code, fvalid); end
    trap = 1'b1; trap_vec = 32'h203;
    step();
    trap = 1'b0;
    checks++; if (pc_f !== 32'h200 || code !== 4'hF || fvalid !== 1'b1) begin errors++; $display("FAIL trap_vec: got %h/%h/%b exp 200/F/1", pc_f, code, fvalid); end
    step();
    checks++; if (pc_f !== 32'h204 || fvalid !== 1'b1) begin errors++; $display("FAIL vec_to_run: got %h/%b exp 204/1", pc_f, fvalid); end
  endtask

  task automatic test_double_fault();
    trap = 1'b1; trap_vec = 32'h2000;
    step();
    trap = 1'b0;
    checks++; if (pc_f !== 32'h2000 || code !== 4'h1 || locked !== 1'b0) begin errors++; $display("FAIL vec_fault: got %h/%h/%b exp 2000/1/0", pc_f, code, locked); end
    step();
    checks++; if (locked !== 1'b1 || pc_f !== 32'h2000 || code !== 4'hF || fvalid !== 1'b0) begin errors++; $display("FAIL lock_enter: got %b/%h/%h/%b exp 1/2000/F/0", locked, pc_f, code, fvalid); end
    br_taken = 1'b1; br_target = 32'h40; mret = 1'b1; mepc = 32'h80; trap = 1'b1; trap_vec = 32'h300;
    step();
    step();
    br_taken = 1'b0; mret = 1'b0; trap = 1'b0;
    checks++; if (locked !== 1'b1 || pc_f !== 32'h2000) begin errors++; $display("FAIL lock_ignore: got %b/%h exp 1/2000", locked, pc_f); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0 || pc_f !== 32'h0) begin errors++; $display("FAIL lock_reset: got %b/%h exp 0/0", locked, pc_f); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_mret_clken();
    mret = 1'b1; mepc = 32'h3FC;
    step();
    mret = 1'b0;
    checks++; if (pc_f !== 32'h3FC || fvalid !== 1'b1 || imem_addr !== 10'hFF || pc_p4_f !== 32'h400) begin errors++; $display("FAIL mret: got %h/%b/%h/%h exp 3FC/1/FF/400", pc_f, fvalid, imem_addr, pc_p4_f); end
    clk_en = 1'b0; br_taken = 1'b1; br_target = 32'h500;
    step();
    step();
    checks++; if (pc_f !== 32'h3FC) begin errors++; $display("FAIL clk_en_hold: got %h exp %h", pc_f, 32'h3FC); end
    clk_en = 1'b1; br_taken = 1'b0;
    step();
    checks++; if (pc_f !== 32'h400 || fvalid !== 1'b1) begin errors++; $display("FAIL clk_en_resume: got %h/%b exp 400/1", pc_f, fvalid); end
    br_taken = 1'b1; br_target = 32'hFFC;
    step();
    br_taken = 1'b0;
    checks++; if (imem_addr !== 10'h3FF || fvalid !== 1'b1) begin errors++; $display("FAIL top_word: got %h/%b exp 3FF/1", imem_addr, fvalid); end
    step();
    checks++; if (pc_f !== 32'h1000 || code !== 4'h1 || fvalid !== 1'b0) begin errors++; $display("FAIL range_edge: got %h/%h/%b exp 1000/1/0", pc_f, code, fvalid); end
    mret = 1'b1; mepc = 32'h3FE;
    step();
    mret = 1'b0;
    checks++; if (pc_f !== 32'h3FE || code !== 4'h0) begin errors++; $display("FAIL mret_misal: got %h/%h exp 3FE/0", pc_f, code); end
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    checks++; if (code !== 4'h1 || pc_p4_f !== 32'h0) begin errors++; $display("FAIL wrap_p4: got %h/%h exp 1/0", code, pc_p4_f); end
    step();
    checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pend: got %h exp FFFFFFFC", pc_f); end
  endtask

  task automatic test_reset_pend();
    br_taken = 1'b1; br_target = 32'h102;
    step();
    br_taken = 1'b0;
    step();
    checks++; if (pc_f !== 32'h102 || code !== 4'h0) begin errors++; $display("FAIL pre_reset_pend: got %h/%h exp 102/0", pc_f, code); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_f !== 32'h0 || code !== 4'hF || fvalid !== 1'b1) begin errors++; $display("FAIL async_reset: got %h/%h/%b exp 0/F/1", pc_f, code, fvalid); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL post_reset_run: got %h exp 4", pc_f); end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; pc_stall = 1'b0;
    br_taken = 1'b0; br_target = 32'h0;
    trap = 1'b0; trap_vec = 32'h0;
    mret = 1'b0; mepc = 32'h0;
    test_reset();
    test_stall_branch();
    test_pend_trap();
    test_double_fault();
    test_mret_clken();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
